// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one memory command port among NUM_REQ requesters with round-robin
// arbitration. A tag table records which requester owns each in-flight load,
// so returning data can be steered back to its issuer. Loads are capped per
// requester, and two tag protocol errors are flagged.
module mem_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int TAG_W           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_is_store,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [1:0]                proc2mem_command,
    output logic [ADDR_W-1:0]         proc2mem_addr,
    output logic [DATA_W-1:0]         proc2mem_data,
    input  logic [TAG_W-1:0]          mem2proc_transaction_tag,
    input  logic [DATA_W-1:0]         mem2proc_data,
    input  logic [TAG_W-1:0]          mem2proc_data_tag,
    output logic                      idle,
    output logic                      err_unexp_tag,
    output logic                      err_tag_reuse
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int NTAG  = 1 << TAG_W;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_cmd_e;

    // Architectural state
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic [CNT_W-1:0] cnt_d [NUM_REQ];
    logic [NTAG-1:0]  tbl_vld_q;
    logic [ID_W-1:0]  tbl_own_q [NTAG];
    logic             err_unexp_q, err_unexp_d;
    logic             err_reuse_q, err_reuse_d;

    // Grant path
    logic [NUM_REQ-1:0] elig;
    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_store;
    int                 scan_idx;
    mem_cmd_e           cmd;
    logic               accept;
    logic               acc_load;

    // Response path
    logic               rsp_hit;
    logic               rsp_miss;
    logic [ID_W-1:0]    rsp_own;
    logic               tag_clr_same;
    logic               reuse_hit;
    logic               busy;

    // A load-only requester at its outstanding limit sits out; stores are
    // never throttled. Reset masks everyone so req_rdy drops immediately.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign elig[i] = !rst && req_vld[i] &&
                         (req_is_store[i] || (cnt_q[i] < CNT_W'(MAX_OUTSTANDING)));
    end

    // Round-robin scan: first eligible requester at or above the pointer.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_q) + k) % NUM_REQ;
            if (!gnt_vld && elig[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(scan_idx);
            end
        end
    end

    // Drive the granted request onto the memory port, or an idle command.
    always_comb begin
        cmd           = MEM_NONE;
        gnt_store     = 1'b0;
        proc2mem_addr = '0;
        proc2mem_data = '0;
        if (gnt_vld) begin
            gnt_store     = req_is_store[gnt_id];
            cmd           = gnt_store ? MEM_STORE : MEM_LOAD;
            proc2mem_addr = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
            proc2mem_data = req_data[int'(gnt_id)*DATA_W +: DATA_W];
        end
    end

    assign proc2mem_command = cmd;

    // Stores always go through; a load needs a nonzero tag from memory.
    assign accept   = gnt_vld && (gnt_store || (mem2proc_transaction_tag != '0));
    assign acc_load = accept && !gnt_store;

    // One-hot acknowledge of the accepted request.
    always_comb begin
        req_rdy = '0;
        if (accept) req_rdy[gnt_id] = 1'b1;
    end

    // Look up the owner of returning data.
    assign rsp_hit  = (mem2proc_data_tag != '0) && tbl_vld_q[mem2proc_data_tag];
    assign rsp_miss = (mem2proc_data_tag != '0) && !tbl_vld_q[mem2proc_data_tag];
    assign rsp_own  = tbl_own_q[mem2proc_data_tag];

    // Steer returned data to its owner; data bus stays zero otherwise.
    always_comb begin
        rsp_vld  = '0;
        rsp_data = '0;
        if (rsp_hit) begin
            rsp_vld[rsp_own] = 1'b1;
            rsp_data         = mem2proc_data;
        end
    end

    // Retiring and reallocating the same tag in one cycle is legal; only a
    // hit on an entry that stays live counts as reuse.
    assign tag_clr_same = rsp_hit && (mem2proc_data_tag == mem2proc_transaction_tag);
    assign reuse_hit    = acc_load && tbl_vld_q[mem2proc_transaction_tag] && !tag_clr_same;

    assign err_unexp_d = err_unexp_q | rsp_miss;
    assign err_reuse_d = err_reuse_q | reuse_hit;

    // Pointer moves past the winner only when it was actually accepted.
    always_comb begin
        rr_d = rr_q;
        if (accept) rr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end

    // Per-requester in-flight count; inc and dec on the same cycle cancel.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (acc_load && (int'(gnt_id) == i)) cnt_d[i] = cnt_d[i] + CNT_W'(1);
            if (rsp_hit && (int'(rsp_own) == i)) cnt_d[i] = cnt_d[i] - CNT_W'(1);
        end
    end

    // Idle means nothing in flight and nobody asking.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_q[i] != '0) busy = 1'b1;
        end
    end

    assign idle          = !(|req_vld) && !busy;
    assign err_unexp_tag = err_unexp_q;
    assign err_tag_reuse = err_reuse_q;

    // Round-robin pointer, counters and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            err_unexp_q <= 1'b0;
            err_reuse_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            rr_q        <= rr_d;
            err_unexp_q <= err_unexp_d;
            err_reuse_q <= err_reuse_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Tag table: the clear is written before the allocation so that a new
    // load on a just-returned tag leaves the entry valid with the new owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_vld_q <= '0;
            for (int t = 0; t < NTAG; t++) tbl_own_q[t] <= '0;
        end else begin
            if (rsp_hit) tbl_vld_q[mem2proc_data_tag] <= 1'b0;
            if (acc_load) begin
                tbl_vld_q[mem2proc_transaction_tag] <= 1'b1;
                tbl_own_q[mem2proc_transaction_tag] <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares whenever the DUT asserts
// req_rdy or rsp_vld. Cycle-specific checks (stalls, flags) are inline.
module tb_mem_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TW = 4;
    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_vld, req_is_store, req_rdy, rsp_vld;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [DW-1:0]    rsp_data, proc2mem_data, mdata;
    logic [1:0]       proc2mem_command;
    logic [AW-1:0]    proc2mem_addr;
    logic [TW-1:0]    ttag, dtag;
    logic             idle, err_unexp_tag, err_tag_reuse;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NR-1:0] rdy;
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } gnt_t;

    typedef struct {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_vld                  (req_vld),
        .req_is_store             (req_is_store),
        .req_addr                 (req_addr),
        .req_data                 (req_data),
        .req_rdy                  (req_rdy),
        .rsp_vld                  (rsp_vld),
        .rsp_data                 (rsp_data),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (ttag),
        .mem2proc_data            (mdata),
        .mem2proc_data_tag        (dtag),
        .idle                     (idle),
        .err_unexp_tag            (err_unexp_tag),
        .err_tag_reuse            (err_tag_reuse)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented grant/response against the scoreboard.
    initial begin
        gnt_t ge;
        rsp_t re;
        forever begin
            @(negedge clk);
            if (req_rdy != '0) begin
                if (gq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL gnt_unexpected: got rdy=%b expected none", req_rdy);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt_rdy",  64'(req_rdy), 64'(ge.rdy));
                    chk("gnt_cmd",  64'(proc2mem_command), 64'(ge.cmd));
                    chk("gnt_addr", 64'(proc2mem_addr), 64'(ge.addr));
                    chk("gnt_data", proc2mem_data, ge.data);
                end
            end
            if (rsp_vld != '0) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: got vld=%b expected none", rsp_vld);
                end else begin
                    re = rq.pop_front();
                    chk("rsp_vld",  64'(rsp_vld), 64'(re.vld));
                    chk("rsp_data", rsp_data, re.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic clr();
        req_vld = '0; req_is_store = '0; req_addr = '0; req_data = '0;
        ttag = '0; dtag = '0; mdata = '0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic pg(input logic [NR-1:0] r, input logic [1:0] c,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_t g;
        g.rdy = r; g.cmd = c; g.addr = a; g.data = d;
        gq.push_back(g);
    endtask

    task automatic pr(input logic [NR-1:0] v, input logic [DW-1:0] d);
        rsp_t r;
        r.vld = v; r.data = d;
        rq.push_back(r);
    endtask

    // One cycle offering transaction tag t with an expected accepted grant.
    task automatic gcyc(input logic [TW-1:0] t, input logic [NR-1:0] r,
                        input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ttag = t;
        pg(r, c, a, d);
        smp();
        nxt();
        ttag = '0;
    endtask

    // One cycle of returned data; ev=0 means it must be dropped.
    task automatic rcyc(input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [NR-1:0] ev);
        dtag = t; mdata = d;
        if (ev != '0) pr(ev, d);
        smp();
        if (ev == '0) begin
            chk("drop_rsp_vld",  64'(rsp_vld), 64'h0);
            chk("drop_rsp_data", rsp_data, 64'h0);
        end
        nxt();
        dtag = '0; mdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        smp();
        chk("rst_rdy",   64'(req_rdy), 64'h0);
        chk("rst_cmd",   64'(proc2mem_command), 64'(C_NONE));
        chk("rst_rsp",   64'(rsp_vld), 64'h0);
        chk("rst_idle",  64'(idle), 64'h1);
        chk("rst_err_u", 64'(err_unexp_tag), 64'h0);
        chk("rst_err_r", 64'(err_tag_reuse), 64'h0);
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        do_reset();

        // Single load, data back five cycles later.
        req_vld = 4'b0001; req_addr[31:0] = 32'h1000; ttag = 4'd3;
        pg(4'b0001, C_LOAD, 32'h1000, 64'h0);
        smp(); chk("t1_idle_req", 64'(idle), 64'h0); nxt();
        clr();
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t1_wait_idle", 64'(idle), 64'h0);
            chk("t1_wait_rsp",  64'(rsp_vld), 64'h0);
            nxt();
        end
        rcyc(4'd3, 64'hDEAD, 4'b0001);
        smp(); chk("t1_idle_after", 64'(idle), 64'h1); nxt();

        // Round robin over all four; store on 3 needs no tag.
        do_reset();
        req_vld = 4'b1111; req_is_store = 4'b1000;
        req_addr = {32'h400, 32'h300, 32'h200, 32'h100};
        req_data[3*DW +: DW] = 64'hCAFE;
        gcyc(4'd1, 4'b0001, C_LOAD,  32'h100, 64'h0);
        gcyc(4'd2, 4'b0010, C_LOAD,  32'h200, 64'h0);
        gcyc(4'd3, 4'b0100, C_LOAD,  32'h300, 64'h0);
        gcyc(4'd0, 4'b1000, C_STORE, 32'h400, 64'hCAFE);
        gcyc(4'd4, 4'b0001, C_LOAD,  32'h100, 64'h0);
        clr();
        rcyc(4'd2, 64'h22, 4'b0010);
        rcyc(4'd4, 64'h44, 4'b0001);
        rcyc(4'd1, 64'h11, 4'b0001);
        rcyc(4'd3, 64'h33, 4'b0100);
        smp(); chk("t2_idle", 64'(idle), 64'h1); nxt();

        // Outstanding limit on requester 1.
        do_reset();
        req_vld = 4'b0010; req_addr[1*AW +: AW] = 32'h2000;
        for (int i = 1; i <= 4; i++) gcyc(TW'(i), 4'b0010, C_LOAD, 32'h2000, 64'h0);
        ttag = 4'd5;
        smp();
        chk("lim_cmd", 64'(proc2mem_command), 64'(C_NONE));
        chk("lim_rdy", 64'(req_rdy), 64'h0);
        chk("lim_addr", 64'(proc2mem_addr), 64'h0);
        nxt();
        dtag = 4'd2; mdata = 64'h77; pr(4'b0010, 64'h77);
        smp(); chk("lim_cmd_ret", 64'(proc2mem_command), 64'(C_NONE)); nxt();
        dtag = '0; mdata = '0;
        gcyc(4'd5, 4'b0010, C_LOAD, 32'h2000, 64'h0);
        clr();

        // Rejected loads keep the pointer on requester 0.
        do_reset();
        req_vld = 4'b0101;
        req_addr[0*AW +: AW] = 32'h400; req_addr[2*AW +: AW] = 32'h600;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rej_rdy",  64'(req_rdy), 64'h0);
            chk("rej_cmd",  64'(proc2mem_command), 64'(C_LOAD));
            chk("rej_addr", 64'(proc2mem_addr), 64'h400);
            nxt();
        end
        gcyc(4'd7, 4'b0001, C_LOAD, 32'h400, 64'h0);
        gcyc(4'd8, 4'b0100, C_LOAD, 32'h600, 64'h0);
        clr();

        // Same-cycle return and reallocation of tag 5, then a real reuse.
        do_reset();
        req_vld = 4'b0001; req_addr[0*AW +: AW] = 32'h500;
        gcyc(4'd5, 4'b0001, C_LOAD, 32'h500, 64'h0);
        req_vld = 4'b0100; req_addr[2*AW +: AW] = 32'h600;
        dtag = 4'd5; mdata = 64'h5555; pr(4'b0001, 64'h5555);
        gcyc(4'd5, 4'b0100, C_LOAD, 32'h600, 64'h0);
        clr();
        smp(); chk("same_no_reuse", 64'(err_tag_reuse), 64'h0); nxt();
        rcyc(4'd5, 64'h6666, 4'b0100);
        req_vld = 4'b0001; req_addr[0*AW +: AW] = 32'h500;
        gcyc(4'd6, 4'b0001, C_LOAD, 32'h500, 64'h0);
        req_vld = 4'b0010; req_addr[1*AW +: AW] = 32'h510;
        gcyc(4'd6, 4'b0010, C_LOAD, 32'h510, 64'h0);
        clr();
        smp(); chk("reuse_err", 64'(err_tag_reuse), 64'h1); nxt();
        rcyc(4'd6, 64'h66, 4'b0010);
        smp();
        chk("reuse_sticky", 64'(err_tag_reuse), 64'h1);
        chk("reuse_leak_busy", 64'(idle), 64'h0);
        nxt();

        // Unknown tag, then reset in the middle of a flight.
        do_reset();
        rcyc(4'd9, 64'h99, 4'b0000);
        smp(); chk("unexp_set", 64'(err_unexp_tag), 64'h1); nxt();
        smp(); chk("unexp_sticky", 64'(err_unexp_tag), 64'h1); nxt();
        req_vld = 4'b0001; req_addr[0*AW +: AW] = 32'h700;
        gcyc(4'd3, 4'b0001, C_LOAD, 32'h700, 64'h0);
        req_vld = 4'b0001; ttag = 4'd4;
        rst = 1'b1;
        smp();
        chk("mid_rst_rdy",   64'(req_rdy), 64'h0);
        chk("mid_rst_cmd",   64'(proc2mem_command), 64'(C_NONE));
        chk("mid_rst_err_u", 64'(err_unexp_tag), 64'h0);
        chk("mid_rst_err_r", 64'(err_tag_reuse), 64'h0);
        nxt();
        rst = 1'b0;
        clr();
        smp(); chk("post_rst_idle", 64'(idle), 64'h1); nxt();
        rcyc(4'd3, 64'hAB, 4'b0000);
        smp(); chk("post_rst_unexp", 64'(err_unexp_tag), 64'h1); nxt();

        smp();
        chk("gnt_q_empty", 64'(gq.size()), 64'h0);
        chk("rsp_q_empty", 64'(rq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
